// File: rtl/snake_mover.sv
// Snake position state: head, shifting body segments and travel direction.
// The head advances once per tick, growth is applied on the move, and self-collision latches dead.
module snake_mover #(
  parameter int max_len = 16,
  parameter int num_len = 10,
  parameter int max_len_bit_len = 4,
  parameter logic [num_len-1:0] start_pos = 10'h210
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tick,
  input  logic [1:0]                   dir_in,
  input  logic                         dir_valid,
  input  logic                         grow,
  output logic [num_len-1:0]           snake_head,
  output logic [max_len*num_len-1:0]   snake_body,
  output logic [max_len_bit_len-1:0]   tail_count,
  output logic                         dead,
  output logic                         moved
);

  localparam int HALF = num_len / 2;
  localparam logic [max_len_bit_len-1:0] TC_MAX = max_len_bit_len'(max_len - 1);

  typedef logic [num_len-1:0] pos_t;

  pos_t       body [max_len];
  logic [1:0] cur_dir;
  logic [1:0] pend_dir;
  logic       grow_pend;
  pos_t       next_head;
  logic       eff_grow;
  logic       hit;

  // Each half of the position wraps independently, so the board is a torus.
  function automatic pos_t step_pos(input pos_t p, input logic [1:0] d);
    logic [HALF-1:0] row;
    logic [HALF-1:0] col;
    row = p[num_len-1:HALF];
    col = p[HALF-1:0];
    case (d)
      2'b00:   col = col + HALF'(1);
      2'b01:   row = row + HALF'(1);
      2'b10:   col = col - HALF'(1);
      default: row = row - HALF'(1);
    endcase
    return {row, col};
  endfunction

  assign eff_grow  = grow_pend | grow;
  assign next_head = step_pos(snake_head, pend_dir);

  // Without growth the last segment vacates this move, so it is not an obstacle.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < max_len; i++) begin
      if (eff_grow ? (i < int'(tail_count)) : (i + 1 < int'(tail_count))) begin
        if (body[i] == next_head) hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snake_head <= start_pos;
      for (int i = 0; i < max_len; i++) body[i] <= start_pos;
      tail_count <= '0;
      dead       <= 1'b0;
      moved      <= 1'b0;
      cur_dir    <= 2'b00;
      pend_dir   <= 2'b00;
      grow_pend  <= 1'b0;
    end else begin
      moved <= 1'b0;
      // A reversal is judged against the direction actually travelled, not the pending one.
      if (dir_valid && (dir_in != (cur_dir ^ 2'b10))) pend_dir <= dir_in;
      if (grow) grow_pend <= 1'b1;
      if (tick && !dead) begin
        if (hit) begin
          dead <= 1'b1;
        end else begin
          snake_head <= next_head;
          body[0]    <= snake_head;
          for (int i = 1; i < max_len; i++) body[i] <= body[i-1];
          cur_dir    <= pend_dir;
          moved      <= 1'b1;
          grow_pend  <= 1'b0;
          if (eff_grow && (tail_count != TC_MAX))
            tail_count <= tail_count + max_len_bit_len'(1);
        end
      end
    end
  end

  for (genvar g = 0; g < max_len; g++) begin : g_flat
    assign snake_body[g*num_len +: num_len] = body[g];
  end

endmodule

// File: tb/tb_snake_mover.sv
// Directed bench for snake_mover: vector table for movement, turning, growth and
// collision, plus hand sequences for wrap-around, saturation and async reset.
module tb_snake_mover;

  logic         clk = 1'b0;
  logic         rst;
  logic         tick;
  logic [1:0]   dir_in;
  logic         dir_valid;
  logic         grow;
  logic [9:0]   snake_head;
  logic [159:0] snake_body;
  logic [3:0]   tail_count;
  logic         dead;
  logic         moved;

  int tests = 0;
  int fails = 0;

  snake_mover dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .dir_in     (dir_in),
    .dir_valid  (dir_valid),
    .grow       (grow),
    .snake_head (snake_head),
    .snake_body (snake_body),
    .tail_count (tail_count),
    .dead       (dead),
    .moved      (moved)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       tk;
    logic       dv;
    logic [1:0] dir;
    logic       gr;
    logic [9:0] head;
    logic [9:0] slot0;
    logic [3:0] tc;
    logic       dd;
    logic       mv;
  } vec_t;

  vec_t vecs[21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] slot(input int i);
    return snake_body[i*10 +: 10];
  endfunction

  // Apply one cycle of inputs, let the edge sample them, then settle just after it.
  task automatic step(input logic tk, input logic dv, input logic [1:0] dir, input logic gr);
    tick = tk; dir_valid = dv; dir_in = dir; grow = gr;
    @(posedge clk);
    #1;
    tick = 1'b0; dir_valid = 1'b0; dir_in = 2'b00; grow = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_head"}, 32'(snake_head), 32'h210);
    chk({tag, "_tc"},   32'(tail_count), 32'h0);
    chk({tag, "_dead"}, 32'(dead), 32'h0);
    chk({tag, "_moved"}, 32'(moved), 32'h0);
    chk({tag, "_slot0"}, 32'(slot(0)), 32'h210);
  endtask

  // Reset is raised and checked between clock edges, before any edge can act on it.
  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1 check_reset_values(tag);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; dir_in = 2'b00; dir_valid = 1'b0; grow = 1'b0;
    //            tk dv dir   gr head    slot0   tc  dd mv
    vecs[0]  = '{1, 0, 2'b00, 0, 10'h211, 10'h210, 0, 0, 1};
    vecs[1]  = '{0, 0, 2'b00, 0, 10'h211, 10'h210, 0, 0, 0};
    vecs[2]  = '{1, 0, 2'b00, 0, 10'h212, 10'h211, 0, 0, 1};
    vecs[3]  = '{1, 0, 2'b00, 0, 10'h213, 10'h212, 0, 0, 1};
    vecs[4]  = '{0, 1, 2'b10, 0, 10'h213, 10'h212, 0, 0, 0};
    vecs[5]  = '{1, 0, 2'b00, 0, 10'h214, 10'h213, 0, 0, 1};
    vecs[6]  = '{0, 1, 2'b01, 0, 10'h214, 10'h213, 0, 0, 0};
    vecs[7]  = '{1, 0, 2'b00, 0, 10'h234, 10'h214, 0, 0, 1};
    vecs[8]  = '{1, 0, 2'b00, 1, 10'h254, 10'h234, 1, 0, 1};
    vecs[9]  = '{1, 0, 2'b00, 1, 10'h274, 10'h254, 2, 0, 1};
    vecs[10] = '{1, 0, 2'b00, 1, 10'h294, 10'h274, 3, 0, 1};
    vecs[11] = '{1, 0, 2'b00, 1, 10'h2B4, 10'h294, 4, 0, 1};
    vecs[12] = '{1, 0, 2'b00, 0, 10'h2D4, 10'h2B4, 4, 0, 1};
    vecs[13] = '{0, 1, 2'b10, 0, 10'h2D4, 10'h2B4, 4, 0, 0};
    vecs[14] = '{1, 0, 2'b00, 0, 10'h2D3, 10'h2D4, 4, 0, 1};
    vecs[15] = '{0, 1, 2'b11, 0, 10'h2D3, 10'h2D4, 4, 0, 0};
    vecs[16] = '{1, 0, 2'b00, 0, 10'h2B3, 10'h2D3, 4, 0, 1};
    vecs[17] = '{0, 1, 2'b00, 0, 10'h2B3, 10'h2D3, 4, 0, 0};
    vecs[18] = '{1, 0, 2'b00, 0, 10'h2B3, 10'h2D3, 4, 1, 0};
    vecs[19] = '{1, 0, 2'b00, 0, 10'h2B3, 10'h2D3, 4, 1, 0};
    vecs[20] = '{1, 0, 2'b00, 1, 10'h2B3, 10'h2D3, 4, 1, 0};

    #3 check_reset_values("rst_hold");
    #9 rst = 1'b0;
    check_reset_values("rst_rel");

    for (int k = 0; k < 21; k++) begin
      step(vecs[k].tk, vecs[k].dv, vecs[k].dir, vecs[k].gr);
      chk($sformatf("v%0d_head", k),  32'(snake_head), 32'(vecs[k].head));
      chk($sformatf("v%0d_slot0", k), 32'(slot(0)),   32'(vecs[k].slot0));
      chk($sformatf("v%0d_tc", k),    32'(tail_count), 32'(vecs[k].tc));
      chk($sformatf("v%0d_dead", k),  32'(dead),       32'(vecs[k].dd));
      chk($sformatf("v%0d_moved", k), 32'(moved),      32'(vecs[k].mv));
      if (k == 11) begin
        chk("shift_slot1", 32'(slot(1)), 32'h274);
        chk("shift_slot2", 32'(slot(2)), 32'h254);
        chk("shift_slot3", 32'(slot(3)), 32'h234);
      end
    end

    async_reset("rst_dead");

    // Column wrap: 15 moves right reach col 31, the 16th wraps to col 0.
    for (int k = 0; k < 15; k++) step(1, 0, 2'b00, 0);
    chk("col31_head", 32'(snake_head), 32'h21F);
    step(1, 0, 2'b00, 0);
    chk("colwrap_head", 32'(snake_head), 32'h200);
    // Row wrap: turn up, 16 moves reach row 0, the next wraps to row 31.
    step(0, 1, 2'b11, 0);
    for (int k = 0; k < 16; k++) step(1, 0, 2'b00, 0);
    chk("row0_head", 32'(snake_head), 32'h000);
    step(1, 0, 2'b00, 0);
    chk("rowwrap_head", 32'(snake_head), 32'h3E0);
    chk("rowwrap_tc", 32'(tail_count), 32'h0);
    chk("rowwrap_dead", 32'(dead), 32'h0);

    async_reset("rst_wrap");

    // A grow pulse without a tick is held and applied on the next move.
    step(0, 0, 2'b00, 1);
    chk("growpend_tc0", 32'(tail_count), 32'h0);
    step(1, 0, 2'b00, 0);
    chk("growpend_tc1", 32'(tail_count), 32'h1);
    step(1, 0, 2'b00, 0);
    chk("growpend_clear", 32'(tail_count), 32'h1);
    for (int k = 0; k < 14; k++) step(1, 0, 2'b00, 1);
    chk("sat_tc15", 32'(tail_count), 32'hF);
    step(1, 0, 2'b00, 1);
    step(1, 0, 2'b00, 1);
    chk("sat_hold_tc", 32'(tail_count), 32'hF);
    chk("sat_head", 32'(snake_head), 32'h202);
    chk("sat_dead", 32'(dead), 32'h0);
    chk("sat_slot0", 32'(slot(0)), 32'h201);

    async_reset("rst_sat");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
